// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble) with a
// start/busy/done handshake and an illegal-digit flag.

// Per-digit cell: post-shift correction of one BCD nibble plus illegal-digit detect.
module bcd_digit_fix (
    input  logic [3:0] nib_sh,
    input  logic [3:0] nib_in,
    output logic [3:0] nib_fix,
    output logic       bad
);
    always_comb begin
        nib_fix = (nib_sh >= 4'd8) ? nib_sh - 4'd3 : nib_sh;
        bad     = (nib_in > 4'd9);
    end
endmodule

module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int SW = 4*DIGITS + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, FAIL} state_t;

    state_t                    state, state_nx;
    logic [SW-1:0]             sr, sr_sh, sr_fix;
    logic [CW-1:0]             cnt;
    logic [DIGITS-1:0][3:0]    fix_vec;
    logic [DIGITS-1:0]         bad_vec;
    logic                      accept, last;

    assign sr_sh = sr >> 1;

    // BCD digits live above the binary field; digit DIGITS-1 is most significant.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit_fix u_dig (
            .nib_sh  (sr_sh[BIN_W + 4*g +: 4]),
            .nib_in  (bcd_in[4*g +: 4]),
            .nib_fix (fix_vec[g]),
            .bad     (bad_vec[g])
        );
    end

    assign sr_fix = {fix_vec, sr_sh[BIN_W-1:0]};
    assign accept = (state == IDLE) && start;
    assign last   = (state == CONV) && (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (|bad_vec) ? FAIL : CONV;
            CONV: if (cnt == CW'(1)) state_nx = IDLE;
            FAIL: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // done is a single-cycle pulse; it drops on any edge that does not complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            cnt     <= '0;
            bin_out <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                sr  <= {bcd_in, {BIN_W{1'b0}}};
                cnt <= CW'(BIN_W);
                err <= 1'b0;
            end else if (state == CONV) begin
                sr  <= sr_fix;
                cnt <= cnt - CW'(1);
                if (last) begin
                    bin_out <= sr_fix[BIN_W-1:0];
                    done    <= 1'b1;
                end
            end else if (state == FAIL) begin
                bin_out <= '0;
                err     <= 1'b1;
                done    <= 1'b1;
            end
        end
    end
endmodule
